shifter_arbiter: RTL and testbench
==================================

// Module: shifter_arbiter
// PURPOSE
//  Shares one shifter_right_logical datapath between two requesters (A, B) for SLL/SRL/SRA.
//  SLL is built by bit-reversing input and output around the shared right shifter.
//  SRA is built by OR-ing a sign-fill mask onto the logical result.
//  Round-robin arbitration, valid/ready request handshake, registered result held until consumed.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width
//  SHIFT_WIDTH  5   shift-amount width; must equal log2(DATA_WIDTH)
// PORTS
//  clk_i          in   1            clock, all state on rising edge
//  rst_n_i        in   1            asynchronous active-low reset
//  a_valid_i      in   1            requester A presents an operation
//  a_ready_o      out  1            A operation accepted this cycle (valid&ready)
//  a_data_i       in   DATA_WIDTH   A operand
//  a_shamt_i      in   SHIFT_WIDTH  A shift amount
//  a_op_i         in   2            A op: 00 SLL, 01 SRL, 10 SRA, 11 pass-through
//  a_rsp_valid_o  out  1            result for A available on rsp_data_o
//  a_rsp_ready_i  in   1            A consumes result
//  b_valid_i, b_ready_o, b_data_i, b_shamt_i, b_op_i, b_rsp_valid_o, b_rsp_ready_i: same for B
//  rsp_data_o     out  DATA_WIDTH   registered result, valid for whichever *_rsp_valid_o is high
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): state=IDLE, a/b_rsp_valid_o=0, rsp_data_o=0, last_grant=B.
//    All *_ready_o are 0 while rst_n_i=0. Reset mid-operation discards the pending result.
//  - FSM: IDLE, HOLD.
//    IDLE: grant computed combinationally from valids:
//      only one valid -> that requester; both valid -> requester != last_grant; none -> none.
//      granted requester's *_ready_o=1 (other 0). On handshake: operands go through shared
//      shifter combinationally, result registered into rsp_data_o, owner recorded,
//      last_grant<=owner, owner's *_rsp_valid_o<=1, state<=HOLD.
//    HOLD: all *_ready_o=0; rsp_data_o and owner's *_rsp_valid_o stable.
//      Owner's *_rsp_ready_i=1 -> *_rsp_valid_o<=0, state<=IDLE. Non-owner rsp_ready ignored.
//  - Latency: accept in cycle N -> *_rsp_valid_o high from N+1. Max throughput one op per 2 cycles.
//  - *_ready_o depends only on state and valids (no dependence on data/op).
//  - At most one *_rsp_valid_o high at any time.
//  - Datapath (exactly one shifter_right_logical instance):
//    SRL: r = srl(d, s).
//    SLL: r = rev(srl(rev(d), s)), rev = bit reversal over DATA_WIDTH.
//    SRA: r = srl(d, s) | (d[MSB] ? ~srl(all_ones, s) : 0).
//    op 11: r = d unshifted, handshake identical.
//    s=0 returns d for all ops; s=DATA_WIDTH-1 returns 1 bit (SRL/SLL) or full sign (SRA).
//  - Requester dropping *_valid_i without handshake is legal; no state change.
//  - Operands are sampled only on the handshake edge; later input changes never affect rsp_data_o.
// TESTING
//  1 A: d=0x00000001 s=4 op=SLL -> a_ready_o=1 same cycle; next cycle a_rsp_valid_o=1, rsp_data_o=0x00000010.
//  2 B: d=0xfedcba98 s=4 op=SRL -> 0x0fedcba9; same operand op=SRA -> 0xffedcba9; op=SRA s=31 -> 0xffffffff;
//    s=0 any op -> 0xfedcba98; op=11 s=7 -> 0xfedcba98.
//  3 After reset, A and B both valid continuously, rsp_ready tied 1 -> grants A,B,A,B; ops accepted every 2 cycles.
//  4 A result pending, a_rsp_ready_i=0 for 5 cycles with b_valid_i=1 -> b_ready_o=0, rsp_data_o stable;
//    b_rsp_ready_i=1 meanwhile ignored; a_rsp_ready_i=1 -> IDLE, B granted next cycle.
//  5 Accept A, assert rst_n_i=0 asynchronously in HOLD -> a_rsp_valid_o and rsp_data_o drop to 0 immediately;
//    after release state=IDLE and first simultaneous request goes to A.
//  6 Random ops/shamts/data on both ports for 10k ops vs. reference model; check one-hot rsp_valid and in-order per requester.

Source files
------------

// File: rtl/shifter_arbiter.sv
// Two-port round-robin arbiter sharing one logical right shifter for SLL/SRL/SRA/pass.
// Result is registered and held for its owner until that requester consumes it.

module shifter_right_logical #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [SHIFT_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0]  result
);
  // log-depth barrel: stage k shifts by 2^k when shamt[k] is set
  logic [SHIFT_WIDTH:0][DATA_WIDTH-1:0] stg;
  assign stg[0] = data;
  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    assign stg[k+1] = shamt[k] ? (stg[k] >> (1 << k)) : stg[k];
  end
  assign result = stg[SHIFT_WIDTH];
endmodule

module shifter_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [DATA_WIDTH-1:0]  a_data_i,
  input  logic [SHIFT_WIDTH-1:0] a_shamt_i,
  input  logic [1:0]             a_op_i,
  output logic                   a_rsp_valid_o,
  input  logic                   a_rsp_ready_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [DATA_WIDTH-1:0]  b_data_i,
  input  logic [SHIFT_WIDTH-1:0] b_shamt_i,
  input  logic [1:0]             b_op_i,
  output logic                   b_rsp_valid_o,
  input  logic                   b_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]  rsp_data_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic [0:0] state;
  logic       last_grant;  // 0 = A, 1 = B
  logic       owner;
  logic       grant_a, grant_b;

  logic [DATA_WIDTH-1:0]  sel_data, srl_in, srl_out, fill, result;
  logic [SHIFT_WIDTH-1:0] sel_shamt;
  logic [1:0]             sel_op;

  function automatic logic [DATA_WIDTH-1:0] rev(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = x[DATA_WIDTH-1-i];
    return r;
  endfunction

  // Contention goes to whoever was not served last
  always_comb begin
    grant_a = rst_n_i && (state == IDLE) && a_valid_i && (!b_valid_i || last_grant);
    grant_b = rst_n_i && (state == IDLE) && b_valid_i && (!a_valid_i || !last_grant);
  end

  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;

  assign sel_data  = grant_b ? b_data_i  : a_data_i;
  assign sel_shamt = grant_b ? b_shamt_i : a_shamt_i;
  assign sel_op    = grant_b ? b_op_i    : a_op_i;

  assign srl_in = (sel_op == OP_SLL) ? rev(sel_data) : sel_data;

  shifter_right_logical #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_srl (
    .data  (srl_in),
    .shamt (sel_shamt),
    .result(srl_out)
  );

  // Sign-fill mask: bit i is vacated by the shift when i >= DATA_WIDTH - shamt
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fill
    localparam logic [SHIFT_WIDTH:0] POS = (SHIFT_WIDTH+1)'(DATA_WIDTH - 1 - i);
    assign fill[i] = {1'b0, sel_shamt} > POS;
  end

  always_comb begin
    result = sel_data;
    case (sel_op)
      OP_SLL:  result = rev(srl_out);
      OP_SRL:  result = srl_out;
      OP_SRA:  result = srl_out | (sel_data[DATA_WIDTH-1] ? fill : '0);
      default: result = sel_data;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      a_rsp_valid_o <= 1'b0;
      b_rsp_valid_o <= 1'b0;
      rsp_data_o    <= '0;
    end else if (state == IDLE) begin
      if (grant_a || grant_b) begin
        rsp_data_o    <= result;
        owner         <= grant_b;
        last_grant    <= grant_b;
        a_rsp_valid_o <= grant_a;
        b_rsp_valid_o <= grant_b;
        state         <= HOLD;
      end
    end else if (owner ? b_rsp_ready_i : a_rsp_ready_i) begin
      a_rsp_valid_o <= 1'b0;
      b_rsp_valid_o <= 1'b0;
      state         <= IDLE;
    end
  end
endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: directed literal cases plus random traffic checked every
// cycle against a transaction-level model (arithmetic shifts, per-requester result queues).

module tb_shifter_arbiter;
  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready, a_rsp_valid, a_rsp_ready;
  logic          b_valid, b_ready, b_rsp_valid, b_rsp_ready;
  logic [DW-1:0] a_data, b_data, rsp_data;
  logic [SW-1:0] a_shamt, b_shamt;
  logic [1:0]    a_op, b_op;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shifter_arbiter #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data), .a_shamt_i(a_shamt),
    .a_op_i(a_op), .a_rsp_valid_o(a_rsp_valid), .a_rsp_ready_i(a_rsp_ready),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data), .b_shamt_i(b_shamt),
    .b_op_i(b_op), .b_rsp_valid_o(b_rsp_valid), .b_rsp_ready_i(b_rsp_ready),
    .rsp_data_o(rsp_data)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_op(input logic [DW-1:0] d, input logic [SW-1:0] s,
                                           input logic [1:0] op);
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return DW'($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  // Transaction model: who holds the result, who was served last, and what is owed to whom
  logic          m_hold, m_owner, m_last;
  logic [DW-1:0] m_data;
  int            m_ops = 0;
  logic [DW-1:0] qa[$], qb[$];
  logic          exp_ra, exp_rb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_data = '0;
      qa.delete(); qb.delete();
    end else if (!m_hold) begin
      if (a_valid && (!b_valid || m_last)) begin
        m_data = ref_op(a_data, a_shamt, a_op);
        m_owner = 1'b0; m_last = 1'b0; m_hold = 1'b1; qa.push_back(m_data); m_ops++;
      end else if (b_valid) begin
        m_data = ref_op(b_data, b_shamt, b_op);
        m_owner = 1'b1; m_last = 1'b1; m_hold = 1'b1; qb.push_back(m_data); m_ops++;
      end
    end else if (m_owner ? b_rsp_ready : a_rsp_ready) begin
      m_hold = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_ra = rst_n && !m_hold && a_valid && (!b_valid || m_last);
    exp_rb = rst_n && !m_hold && b_valid && !exp_ra;
    chk("a_ready", a_ready, exp_ra);
    chk("b_ready", b_ready, exp_rb);
    chk("a_rsp_valid", a_rsp_valid, m_hold && !m_owner);
    chk("b_rsp_valid", b_rsp_valid, m_hold && m_owner);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_onehot", a_rsp_valid & b_rsp_valid, 0);
    if (a_rsp_valid && a_rsp_ready) begin
      if (qa.size() == 0) chk("a_order_empty", 1, 0);
      else chk("a_in_order", rsp_data, qa.pop_front());
    end
    if (b_rsp_valid && b_rsp_ready) begin
      if (qb.size() == 0) chk("b_order_empty", 1, 0);
      else chk("b_in_order", rsp_data, qb.pop_front());
    end
  end

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; a_rsp_ready = 0; b_rsp_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_b_rsp_valid", b_rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(posedge clk); #3 rst_n = 1;
  endtask

  // One directed op on an idle arbiter, checking handshake, latency and literal result
  task automatic op_lit(input bit who, input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input logic [1:0] op, input logic [DW-1:0] exp, input string name);
    @(posedge clk); #1;
    if (!who) begin a_valid = 1; a_data = d; a_shamt = s; a_op = op; end
    else      begin b_valid = 1; b_data = d; b_shamt = s; b_op = op; end
    @(negedge clk);
    chk({name, "_ready"}, who ? b_ready : a_ready, 1);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    a_data = ~d; b_data = ~d;
    @(negedge clk);
    chk({name, "_rsp_valid"}, who ? b_rsp_valid : a_rsp_valid, 1);
    chk({name, "_data"}, rsp_data, exp);
    @(posedge clk); #1;
    if (who) b_rsp_ready = 1; else a_rsp_ready = 1;
    @(posedge clk); #1;
    a_rsp_ready = 0; b_rsp_ready = 0;
  endtask

  initial begin
    int start, cyc;
    rst_n = 0;
    idle_inputs();
    a_data = '0; b_data = '0; a_shamt = '0; b_shamt = '0; a_op = '0; b_op = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;

    op_lit(0, 32'h00000001, 5'd4,  2'b00, 32'h00000010, "t1_sll");
    op_lit(1, 32'hfedcba98, 5'd4,  2'b01, 32'h0fedcba9, "t2_srl");
    op_lit(1, 32'hfedcba98, 5'd4,  2'b10, 32'hffedcba9, "t2_sra");
    op_lit(1, 32'hfedcba98, 5'd31, 2'b10, 32'hffffffff, "t2_sra31");
    op_lit(1, 32'hfedcba98, 5'd0,  2'b00, 32'hfedcba98, "t2_s0_sll");
    op_lit(1, 32'hfedcba98, 5'd0,  2'b01, 32'hfedcba98, "t2_s0_srl");
    op_lit(1, 32'hfedcba98, 5'd0,  2'b10, 32'hfedcba98, "t2_s0_sra");
    op_lit(1, 32'hfedcba98, 5'd7,  2'b11, 32'hfedcba98, "t2_pass");
    op_lit(0, 32'hfedcba98, 5'd31, 2'b00, 32'h00000000, "edge_sll31");
    op_lit(0, 32'h80000001, 5'd31, 2'b01, 32'h00000001, "edge_srl31");

    // both requesters saturating: A, -, B, -, A, ...
    do_reset();
    @(posedge clk); #1;
    a_valid = 1; b_valid = 1; a_rsp_ready = 1; b_rsp_ready = 1;
    a_data = 32'h1; a_shamt = 5'd1; a_op = 2'b00;
    b_data = 32'h8; b_shamt = 5'd1; b_op = 2'b01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t3_a_ready_%0d", i), a_ready, (i % 4) == 0);
      chk($sformatf("t3_b_ready_%0d", i), b_ready, (i % 4) == 2);
    end
    @(posedge clk); #1;
    idle_inputs();

    // A holds its result while B waits; B's rsp_ready must not release A's slot
    @(posedge clk); #1;
    a_valid = 1; a_data = 32'h80000000; a_shamt = 5'd3; a_op = 2'b10;
    @(negedge clk);
    chk("t4_a_ready", a_ready, 1);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 1; b_rsp_ready = 1;
    b_data = 32'h12345678; b_shamt = 5'd8; b_op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_b_blocked", b_ready, 0);
      chk("t4_a_held", a_rsp_valid, 1);
      chk("t4_data_stable", rsp_data, 32'hf0000000);
      @(posedge clk); #1;
    end
    a_rsp_ready = 1;
    @(posedge clk); #1;
    a_rsp_ready = 0;
    @(negedge clk);
    chk("t4_b_granted", b_ready, 1);
    @(posedge clk); #1;
    b_valid = 0;
    @(negedge clk);
    chk("t4_b_rsp_valid", b_rsp_valid, 1);
    chk("t4_b_data", rsp_data, 32'h00123456);
    @(posedge clk); #1;
    b_rsp_ready = 0;

    // reset while holding A's result, then A wins the first contention
    @(posedge clk); #1;
    a_valid = 1; a_data = 32'h0000ffff; a_shamt = 5'd16; a_op = 2'b00;
    @(negedge clk);
    chk("t5_a_ready", a_ready, 1);
    @(posedge clk); #1;
    a_valid = 0;
    @(negedge clk);
    chk("t5_data_before_rst", rsp_data, 32'hffff0000);
    do_reset();
    @(posedge clk); #1;
    a_valid = 1; b_valid = 1;
    @(negedge clk);
    chk("t5_a_first", a_ready, 1);
    chk("t5_b_waits", b_ready, 0);
    @(posedge clk); #1;
    idle_inputs();
    a_rsp_ready = 1;
    @(posedge clk); #1;
    a_rsp_ready = 0;

    // random traffic, including valid drops without handshake
    start = m_ops;
    cyc = 0;
    while ((m_ops - start) < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      a_valid     = ($urandom_range(0, 9) < 8);
      b_valid     = ($urandom_range(0, 9) < 8);
      a_rsp_ready = ($urandom_range(0, 3) != 0);
      b_rsp_ready = ($urandom_range(0, 3) != 0);
      a_data  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b_data  = ($urandom_range(0, 7) == 0) ? 32'hffffffff : $urandom;
      a_shamt = SW'($urandom_range(0, DW - 1));
      b_shamt = SW'($urandom_range(0, DW - 1));
      a_op    = 2'($urandom_range(0, 3));
      b_op    = 2'($urandom_range(0, 3));
      cyc++;
    end
    chk("random_ops_done", (m_ops - start) >= 10000, 1);

    @(posedge clk); #1;
    a_valid = 0; b_valid = 0; a_rsp_ready = 1; b_rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_qa", qa.size(), 0);
    chk("drain_qb", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
